// File: rtl/get_d_seq_if.sv
// get_d_seq_if: control, operand and digit-stream signals of the get_d_seq
// sequential BKM digit selector.
//   master : the digit producer (get_d_seq itself)
//   slave  : the host that starts operations and consumes the digits
interface get_d_seq_if #(
  parameter int W     = 8,
  parameter int IDX_W = 4
);
  // operation launch
  logic                 start;
  logic                 mode;
  logic signed [W-1:0]  u_in;
  logic signed [W-1:0]  v_in;
  // status
  logic                 busy;
  logic                 done;
  logic                 err;
  // digit stream (valid/ready)
  logic                 d_valid;
  logic                 d_ready;
  logic signed [1:0]    d_x;
  logic signed [1:0]    d_y;
  logic [IDX_W-1:0]     d_idx;

  modport master (
    input  start, mode, u_in, v_in, d_ready,
    output busy, done, err, d_valid, d_x, d_y, d_idx
  );

  modport slave (
    output start, mode, u_in, v_in, d_ready,
    input  busy, done, err, d_valid, d_x, d_y, d_idx
  );
endinterface

// File: rtl/get_d_seq.sv
// get_d_seq: sequential BKM digit selector.
// Loads the complex residual (u,v) on start, then emits one digit pair
// (d_x,d_y) in {-1,0,+1} per accepted handshake, doubling the residuals and
// removing the selected digit after each transfer.  mode=1 negates the
// emitted digits only; the residual recurrence always uses the raw digit.
// Optional build macro GET_D_SEQ_EARLY_TERM_EN: when defined, the operation
// ends as soon as both residuals become zero after a transfer, so trailing
// all-zero digits are not emitted.  Undefined: exactly N_ITER digits.
module get_d_seq #(
  parameter int W      = 8,   // residual width, two's complement, W >= FRAC+2
  parameter int FRAC   = 6,   // fractional bits, 1.0 == 2^FRAC
  parameter int N_ITER = 8,   // digits per operation, >= 1
  parameter int IDX_W  = 4    // digit index width, 2^IDX_W >= N_ITER
) (
  input  logic          clk,
  input  logic          rst_n,
  get_d_seq_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fixed-point constants: ONE = 1.0, HALF = 0.5 in residual units.
  localparam logic signed [W-1:0] ONE_C      = W'(2 ** FRAC);
  localparam logic signed [W-1:0] NEG_ONE_C  = W'(-(2 ** FRAC));
  localparam logic signed [W-1:0] MAX_C      = W'((2 ** FRAC) - 1);
  localparam logic signed [W-1:0] HALF_C     = W'(2 ** (FRAC - 1));
  localparam logic signed [W-1:0] NEG_HALF_C = W'(-(2 ** (FRAC - 1)));
  localparam logic [IDX_W-1:0]    LAST_IDX_C = IDX_W'(N_ITER - 1);
  localparam logic signed [W-1:0] ZERO_C     = {W{1'b0}};

  // Digit selection: +1 at or above +0.5, -1 strictly below -0.5, else 0.
  // A residual of exactly -0.5 therefore selects 0 (strict compare).
  function automatic logic signed [1:0] sel_digit(input logic signed [W-1:0] r);
    logic signed [1:0] d;
    if (r >= HALF_C) begin
      d = 2'sb01;
    end else if (r < NEG_HALF_C) begin
      d = 2'sb11;
    end else begin
      d = 2'sb00;
    end
    return d;
  endfunction

  // Residual recurrence r' = 2r - d*ONE, wrapping at W bits.
  function automatic logic signed [W-1:0] next_res(input logic signed [W-1:0] r,
                                                   input logic signed [1:0]   d);
    logic signed [W-1:0] n;
    case (d)
      2'sb01:  n = (r <<< 1) - ONE_C;
      2'sb11:  n = (r <<< 1) + ONE_C;
      default: n = r <<< 1;
    endcase
    return n;
  endfunction

  // Operand range check: [-1.0, 1.0 - ulp].
  function automatic logic in_range(input logic signed [W-1:0] r);
    return (r >= NEG_ONE_C) && (r <= MAX_C);
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic signed [W-1:0]  u_r;
  logic signed [W-1:0]  v_r;
  logic                 mode_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 err_r;

  logic signed [1:0]    dx_raw_s;
  logic signed [1:0]    dy_raw_s;
  logic signed [W-1:0]  u_nxt_s;
  logic signed [W-1:0]  v_nxt_s;
  logic                 xfer_s;
  logic                 last_s;
  logic                 zero_end_s;
  logic                 start_ok_s;

  // Digit selection and the candidate next residuals for the current digit.
  always_comb begin
    dx_raw_s   = sel_digit(u_r);
    dy_raw_s   = sel_digit(v_r);
    u_nxt_s    = next_res(u_r, dx_raw_s);
    v_nxt_s    = next_res(v_r, dy_raw_s);
    xfer_s     = (state_r == ST_RUN) && bus.d_ready;
    last_s     = (idx_r == LAST_IDX_C);
    start_ok_s = (state_r == ST_IDLE) && bus.start;
`ifdef GET_D_SEQ_EARLY_TERM_EN
    // Both residuals zero after this digit: every later digit would be 0.
    zero_end_s = (u_nxt_s == ZERO_C) && (v_nxt_s == ZERO_C);
`else
    zero_end_s = 1'b0;
`endif
  end

  // Next-state logic; DONE lasts exactly one cycle and returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (xfer_s && (last_s || zero_end_s)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand load on accepted start, residual/index advance on each transfer.
  // Out-of-range operands are flagged but still processed with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_r    <= ZERO_C;
      v_r    <= ZERO_C;
      mode_r <= 1'b0;
      idx_r  <= {IDX_W{1'b0}};
      err_r  <= 1'b0;
    end else if (start_ok_s) begin
      u_r    <= bus.u_in;
      v_r    <= bus.v_in;
      mode_r <= bus.mode;
      idx_r  <= {IDX_W{1'b0}};
      err_r  <= !(in_range(bus.u_in) && in_range(bus.v_in));
    end else if (xfer_s) begin
      u_r <= u_nxt_s;
      v_r <= v_nxt_s;
      // The index saturates at the final digit so it never wraps.
      if (!last_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  // Output decode: every output is a direct function of registered state;
  // digits read as zero whenever no digit is offered.
  always_comb begin
    bus.d_valid = (state_r == ST_RUN);
    bus.busy    = (state_r == ST_RUN);
    bus.done    = (state_r == ST_DONE);
    bus.err     = err_r;
    bus.d_idx   = idx_r;
    if (state_r == ST_RUN) begin
      if (mode_r) begin
        bus.d_x = -dx_raw_s;
        bus.d_y = -dy_raw_s;
      end else begin
        bus.d_x = dx_raw_s;
        bus.d_y = dy_raw_s;
      end
    end else begin
      bus.d_x = 2'sb00;
      bus.d_y = 2'sb00;
    end
  end

endmodule
